// File: rtl/uart_frame_rx_if.sv
// ---------------------------------------------------------------------------
// uart_frame_rx_if
//   Pixel write bus between uart_frame_rx and port A of the frame BRAM.
//   Optional macro: UART_RX_PARITY_EN adds the parity_err pulse.
//
//   pixel_data_rec  BIT_DEPTH      received pixel byte (held until next strobe)
//   hcount_rec      $clog2(WIDTH)  column of pixel_data_rec
//   vcount_rec      $clog2(HEIGHT) row of pixel_data_rec
//   data_valid_rec  1              one-cycle BRAM write strobe
//   frame_done      1              one-cycle pulse with the last pixel of a frame
//   framing_err     1              one-cycle pulse: stop bit sampled low
//   parity_err      1              one-cycle pulse: even parity mismatch (8E1 only)
//
//   master: receiver side (drives everything); slave: BRAM side.
// ---------------------------------------------------------------------------
interface uart_frame_rx_if #(
    parameter int WIDTH     = 64,
    parameter int HEIGHT    = 64,
    parameter int BIT_DEPTH = 8
);
    logic [BIT_DEPTH-1:0]      pixel_data_rec;
    logic [$clog2(WIDTH)-1:0]  hcount_rec;
    logic [$clog2(HEIGHT)-1:0] vcount_rec;
    logic                      data_valid_rec;
    logic                      frame_done;
    logic                      framing_err;
`ifdef UART_RX_PARITY_EN
    logic                      parity_err;
`endif

    modport master (
        output pixel_data_rec, hcount_rec, vcount_rec,
        output data_valid_rec, frame_done, framing_err
`ifdef UART_RX_PARITY_EN
        , output parity_err
`endif
    );

    modport slave (
        input pixel_data_rec, hcount_rec, vcount_rec,
        input data_valid_rec, frame_done, framing_err
`ifdef UART_RX_PARITY_EN
        , input parity_err
`endif
    );
endinterface

// File: rtl/uart_frame_rx.sv
// ---------------------------------------------------------------------------
// uart_frame_rx
//   UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN defined) that turns
//   each received byte into one raster-ordered pixel write for the frame BRAM.
//
//   clk_100mhz  in   system clock
//   sys_rst_n   in   asynchronous active-low reset (deasserted synchronously inside)
//   rx          in   asynchronous serial line, idles high
//   clear_i     in   synchronous pulse: next pixel goes to (0,0)
//   pix         master modport of uart_frame_rx_if (pixel data, address, strobes)
//
//   Optional macro: UART_RX_PARITY_EN (even parity bit between data and stop).
// ---------------------------------------------------------------------------
module uart_frame_rx #(
    parameter int CLOCKS_PER_BAUD = 33,
    parameter int WIDTH           = 64,
    parameter int HEIGHT          = 64,
    parameter int BIT_DEPTH       = 8
) (
    input  logic            clk_100mhz,
    input  logic            sys_rst_n,
    input  logic            rx,
    input  logic            clear_i,
    uart_frame_rx_if.master pix
);
    localparam int HW = $clog2(WIDTH);
    localparam int VW = $clog2(HEIGHT);
    localparam int BW = $clog2(CLOCKS_PER_BAUD);
    localparam logic [BW-1:0] BAUD_FULL = BW'(CLOCKS_PER_BAUD - 1);
    localparam logic [BW-1:0] BAUD_HALF = BW'(CLOCKS_PER_BAUD / 2 - 1);
    localparam logic [HW-1:0] H_LAST    = HW'(WIDTH - 1);
    localparam logic [VW-1:0] V_LAST    = VW'(HEIGHT - 1);

    if (BIT_DEPTH != 8) begin : g_bad_bit_depth
        $error("uart_frame_rx: BIT_DEPTH must be 8");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_ERR_WAIT
    } state_t;

    logic [1:0]           r_rst_sync;
    logic                 w_rst_n;
    logic                 r_rx_meta;
    logic                 r_rx_s;
    state_t               r_state, w_state_nxt;
    logic [BW-1:0]        r_baud_cnt, w_baud_nxt;
    logic [2:0]           r_bit_idx, w_bit_nxt;
    logic [7:0]           r_shift, w_shift_nxt;
    logic [HW-1:0]        r_hcnt;
    logic [VW-1:0]        r_vcnt;
    logic                 w_tick;
    logic                 w_stop_sample;
    logic                 w_accept;
    logic                 w_last_pixel;
`ifdef UART_RX_PARITY_EN
    logic                 r_par_bad, w_par_bad_nxt;
`endif

    // NOTE: reset asserts asynchronously but releases on a clock edge, so every
    // flop below leaves reset in the same cycle; a raw async release could split them.
    always_ff @(posedge clk_100mhz or negedge sys_rst_n) begin
        if (!sys_rst_n) r_rst_sync <= 2'b00;
        else            r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk_100mhz or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_rx_meta  <= 1'b1;
            r_rx_s     <= 1'b1;
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
`ifdef UART_RX_PARITY_EN
            r_par_bad  <= 1'b0;
`endif
        end else begin
            r_rx_meta  <= rx;
            r_rx_s     <= r_rx_meta;
            r_state    <= w_state_nxt;
            r_baud_cnt <= w_baud_nxt;
            r_bit_idx  <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
`ifdef UART_RX_PARITY_EN
            r_par_bad  <= w_par_bad_nxt;
`endif
        end
    end

    assign w_tick = (r_baud_cnt == '0);

    // NOTE: every signal gets a default before the case, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt   = r_state;
        w_baud_nxt    = w_tick ? r_baud_cnt : r_baud_cnt - BW'(1);
        w_bit_nxt     = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_stop_sample = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_bad_nxt = r_par_bad;
`endif
        case (r_state)
            S_IDLE: begin
                if (!r_rx_s) begin
                    w_state_nxt = S_START;
                    w_baud_nxt  = BAUD_HALF;
                end
            end
            S_START: begin
                // Mid-start-bit check: a line already back high was a glitch.
                if (w_tick) begin
                    if (!r_rx_s) begin
                        w_state_nxt = S_DATA;
                        w_baud_nxt  = BAUD_FULL;
                        w_bit_nxt   = '0;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    // LSB arrives first, so shift in from the top.
                    w_shift_nxt = {r_rx_s, r_shift[7:1]};
                    w_baud_nxt  = BAUD_FULL;
                    w_bit_nxt   = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (w_tick) begin
                    // Even parity: data bits plus parity bit must XOR to zero.
                    w_par_bad_nxt = ^{r_shift, r_rx_s};
                    w_baud_nxt    = BAUD_FULL;
                    w_state_nxt   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (w_tick) begin
                    w_stop_sample = 1'b1;
                    w_state_nxt   = r_rx_s ? S_IDLE : S_ERR_WAIT;
                end
            end
            S_ERR_WAIT: begin
                // A held-low line (break) must not look like a fresh start bit.
                if (r_rx_s) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

`ifdef UART_RX_PARITY_EN
    assign w_accept = w_stop_sample && r_rx_s && !r_par_bad;
`else
    assign w_accept = w_stop_sample && r_rx_s;
`endif
    assign w_last_pixel = (r_hcnt == H_LAST) && (r_vcnt == V_LAST);

    // Output stage: strobes are registered one cycle after the stop-bit sample,
    // data and address hold between strobes.
    always_ff @(posedge clk_100mhz or negedge w_rst_n) begin
        if (!w_rst_n) begin
            pix.pixel_data_rec <= '0;
            pix.hcount_rec     <= '0;
            pix.vcount_rec     <= '0;
            pix.data_valid_rec <= 1'b0;
            pix.frame_done     <= 1'b0;
            pix.framing_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            pix.parity_err     <= 1'b0;
`endif
        end else begin
            pix.data_valid_rec <= w_accept;
            pix.frame_done     <= w_accept && w_last_pixel;
            pix.framing_err    <= w_stop_sample && !r_rx_s;
`ifdef UART_RX_PARITY_EN
            pix.parity_err     <= w_stop_sample && r_par_bad;
`endif
            if (w_accept) begin
                pix.pixel_data_rec <= r_shift;
                pix.hcount_rec     <= r_hcnt;
                pix.vcount_rec     <= r_vcnt;
            end
        end
    end

    // Next-pixel address. clear_i wins over an advance: the byte being accepted
    // already latched its old address above.
    always_ff @(posedge clk_100mhz or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (clear_i) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (w_accept) begin
            if (r_hcnt == H_LAST) begin
                r_hcnt <= '0;
                r_vcnt <= (r_vcnt == V_LAST) ? '0 : r_vcnt + VW'(1);
            end else begin
                r_hcnt <= r_hcnt + HW'(1);
            end
        end
    end
endmodule

// File: tb/tb_uart_frame_rx.sv
`timescale 1ns/1ps
module tb_uart_frame_rx;
    localparam int CPB = 33;
    localparam int W   = 4;
    localparam int H   = 2;
    localparam int N   = W * H;

    typedef struct packed {
        logic       fd;
        logic [7:0] d;
        logic [1:0] h;
        logic [0:0] v;
    } pix_t;

    logic clk = 1'b0;
    logic sys_rst_n = 1'b0;
    logic rx = 1'b1;
    logic clear_i = 1'b0;

    uart_frame_rx_if #(.WIDTH(W), .HEIGHT(H), .BIT_DEPTH(8)) pix ();

    uart_frame_rx #(.CLOCKS_PER_BAUD(CPB), .WIDTH(W), .HEIGHT(H), .BIT_DEPTH(8)) dut (
        .clk_100mhz (clk),
        .sys_rst_n  (sys_rst_n),
        .rx         (rx),
        .clear_i    (clear_i),
        .pix        (pix.master)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_mis = 0;
    pix_t obs_q[$];
    pix_t exp_q[$];
    int   model_idx = 0;
    int   n_ferr = 0, exp_ferr = 0;
    int   n_perr = 0, exp_perr = 0;
    int   n_fd_stray = 0;
    realtime start_t, valid_t;

    // Passive monitor: records what the DUT emits; the test tasks judge it.
    always @(negedge clk) begin
        if (pix.data_valid_rec) begin
            obs_q.push_back({pix.frame_done, pix.pixel_data_rec, pix.hcount_rec, pix.vcount_rec});
            valid_t = $realtime;
        end
        if (pix.frame_done && !pix.data_valid_rec) n_fd_stray++;
        if (pix.framing_err) n_ferr++;
`ifdef UART_RX_PARITY_EN
        if (pix.parity_err) n_perr++;
`endif
    end

    // Reference model: pixels fill a W x H raster in order, wrapping per frame.
    task automatic model_push(input logic [7:0] b);
        pix_t e;
        e.fd = (model_idx == N - 1);
        e.d  = b;
        e.h  = 2'(model_idx % W);
        e.v  = 1'(model_idx / W);
        exp_q.push_back(e);
        model_idx = (model_idx + 1) % N;
    endtask

    task automatic bit_time(input logic val);
        rx = val;
        repeat (CPB) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input logic par_flip);
        start_t = $realtime;
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
`ifdef UART_RX_PARITY_EN
        bit_time(^b ^ par_flip);
`else
        if (par_flip) start_t = start_t;
`endif
        bit_time(stop_bit);
        rx = 1'b1;
    endtask

    task automatic pulse_clear();
        clear_i = 1'b1;
        @(posedge clk);
        clear_i = 1'b0;
        model_idx = 0;
    endtask

    task automatic test_reset();
        int bad = 0;
        sys_rst_n = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            rx = 1'($urandom);
            @(negedge clk);
            if ({pix.data_valid_rec, pix.frame_done, pix.framing_err,
                 pix.pixel_data_rec, pix.hcount_rec, pix.vcount_rec} !== '0) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_mis++;
            $display("FAIL reset_outputs: %0d cycles with nonzero outputs, required 0", bad);
        end
        @(posedge clk);
        rx = 1'b1;
        sys_rst_n = 1'b1;
        repeat (8) @(posedge clk);
        obs_q.delete();
        n_ferr = 0;
        model_idx = 0;
        send_byte(8'h18, 1'b1, 1'b0);
        model_push(8'h18);
        repeat (4) @(posedge clk);
        n_cmp++;
        if (obs_q.size() !== 1) begin
            n_mis++;
            $display("FAIL first_byte_count: got %0d strobes, required 1", obs_q.size());
        end
        if (obs_q.size() == 1) begin
            // Spec latency: 2 + 9.5*CPB + 1 cycles, +/-1 (with parity one extra bit).
            real lat, want;
            lat = (valid_t - start_t - 5.0) / 10.0;
`ifdef UART_RX_PARITY_EN
            want = 2.0 + 10.5 * CPB + 1.0;
`else
            want = 2.0 + 9.5 * CPB + 1.0;
`endif
            n_cmp++;
            if (lat < want - 1.5 || lat > want + 1.5) begin
                n_mis++;
                $display("FAIL first_byte_latency: got %0.1f cycles, required %0.1f +/-1", lat, want);
            end
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            pix_t e = exp_q.pop_front();
            pix_t o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_mis++;
                $display("FAIL first_byte: got %h, required %h", o, e);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_back_to_back();
        pulse_clear();
        for (int i = 0; i < 8; i++) begin
            send_byte(8'(i), 1'b1, 1'b0);
            model_push(8'(i));
        end
        send_byte(8'hAA, 1'b1, 1'b0);
        model_push(8'hAA);
        repeat (4) @(posedge clk);
        n_cmp++;
        if (obs_q.size() !== exp_q.size()) begin
            n_mis++;
            $display("FAIL b2b_count: got %0d strobes, required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            pix_t e = exp_q.pop_front();
            pix_t o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_mis++;
                $display("FAIL b2b_pixel: got %h, required %h", o, e);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_framing();
        send_byte(8'h55, 1'b0, 1'b0);
        exp_ferr++;
        rx = 1'b0;
        repeat (40 * CPB) @(posedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(posedge clk);
        n_cmp++;
        if (n_ferr !== exp_ferr) begin
            n_mis++;
            $display("FAIL framing_err_pulses: got %0d, required %0d", n_ferr, exp_ferr);
        end
        n_cmp++;
        if (obs_q.size() !== 0) begin
            n_mis++;
            $display("FAIL framing_no_strobe: got %0d strobes, required 0", obs_q.size());
        end
        obs_q.delete();
        send_byte(8'h3C, 1'b1, 1'b0);
        model_push(8'h3C);
        repeat (4) @(posedge clk);
        n_cmp++;
        if (obs_q.size() !== 1 || obs_q[0] !== exp_q[0]) begin
            n_mis++;
            $display("FAIL after_framing: got %0d strobes first %h, required 1 strobe %h",
                     obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : pix_t'(0), exp_q[0]);
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_glitch();
        rx = 1'b0;
        repeat (10) @(posedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(posedge clk);
        n_cmp++;
        if (obs_q.size() !== 0 || n_ferr !== exp_ferr) begin
            n_mis++;
            $display("FAIL glitch: got %0d strobes %0d framing errs, required 0 and %0d",
                     obs_q.size(), n_ferr, exp_ferr);
        end
        obs_q.delete();
        send_byte(8'hC3, 1'b1, 1'b0);
        model_push(8'hC3);
        repeat (4) @(posedge clk);
        n_cmp++;
        if (obs_q.size() !== 1 || obs_q[0] !== exp_q[0]) begin
            n_mis++;
            $display("FAIL after_glitch: got %0d strobes, required 1 strobe %h", obs_q.size(), exp_q[0]);
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_clear_and_reset();
        bit seen = 1'b0;
        send_byte(8'h21, 1'b1, 1'b0); model_push(8'h21);
        send_byte(8'h22, 1'b1, 1'b0); model_push(8'h22);
        repeat (3) @(posedge clk);
        pulse_clear();
        send_byte(8'h7E, 1'b1, 1'b0); model_push(8'h7E);
        // clear_i in the strobe cycle itself: strobe keeps its address.
        fork
            send_byte(8'h11, 1'b1, 1'b0);
            begin
                for (int i = 0; i < 12 * CPB && !seen; i++) begin
                    @(negedge clk);
                    if (pix.data_valid_rec) begin
                        seen = 1'b1;
                        clear_i = 1'b1;
                        @(negedge clk);
                        clear_i = 1'b0;
                    end
                end
            end
        join
        model_push(8'h11);
        model_idx = 0;
        n_cmp++;
        if (!seen) begin
            n_mis++;
            $display("FAIL clear_strobe_wait: got no strobe within %0d cycles, required 1", 12 * CPB);
        end
        send_byte(8'h12, 1'b1, 1'b0); model_push(8'h12);
        repeat (4) @(posedge clk);
        n_cmp++;
        if (obs_q.size() !== exp_q.size()) begin
            n_mis++;
            $display("FAIL clear_count: got %0d strobes, required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            pix_t e = exp_q.pop_front();
            pix_t o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_mis++;
                $display("FAIL clear_pixel: got %h, required %h", o, e);
            end
        end
        exp_q.delete(); obs_q.delete();

        // Reset in the middle of a byte: outputs clear at once, no strobe later.
        bit_time(1'b0);
        bit_time(1'b1);
        bit_time(1'b0);
        @(negedge clk);
        sys_rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({pix.data_valid_rec, pix.frame_done, pix.framing_err,
             pix.pixel_data_rec, pix.hcount_rec, pix.vcount_rec} !== '0) begin
            n_mis++;
            $display("FAIL reset_mid_byte: got data %h h %0d v %0d, required all 0",
                     pix.pixel_data_rec, pix.hcount_rec, pix.vcount_rec);
        end
        rx = 1'b1;
        repeat (5) @(posedge clk);
        sys_rst_n = 1'b1;
        model_idx = 0;
        repeat (12 * CPB) @(posedge clk);
        n_cmp++;
        if (obs_q.size() !== 0 || n_ferr !== exp_ferr) begin
            n_mis++;
            $display("FAIL reset_abort: got %0d strobes %0d framing errs, required 0 and %0d",
                     obs_q.size(), n_ferr, exp_ferr);
        end
        obs_q.delete();
        send_byte(8'h5A, 1'b1, 1'b0); model_push(8'h5A);
        repeat (4) @(posedge clk);
        n_cmp++;
        if (obs_q.size() !== 1 || obs_q[0] !== exp_q[0]) begin
            n_mis++;
            $display("FAIL after_reset: got %0d strobes, required 1 strobe %h", obs_q.size(), exp_q[0]);
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_random();
        for (int i = 0; i < 14; i++) begin
            logic [7:0] b = 8'($urandom);
            int gap = $urandom_range(0, 2);
            send_byte(b, 1'b1, 1'b0);
            model_push(b);
            repeat (gap * CPB) @(posedge clk);
        end
        repeat (4) @(posedge clk);
        n_cmp++;
        if (obs_q.size() !== exp_q.size()) begin
            n_mis++;
            $display("FAIL random_count: got %0d strobes, required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            pix_t e = exp_q.pop_front();
            pix_t o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_mis++;
                $display("FAIL random_pixel: got %h, required %h", o, e);
            end
        end
        exp_q.delete(); obs_q.delete();
        n_cmp++;
        if (n_fd_stray !== 0) begin
            n_mis++;
            $display("FAIL frame_done_alone: got %0d pulses without strobe, required 0", n_fd_stray);
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        send_byte(8'h01, 1'b1, 1'b1);
        exp_perr++;
        repeat (4) @(posedge clk);
        n_cmp++;
        if (n_perr !== exp_perr || obs_q.size() !== 0) begin
            n_mis++;
            $display("FAIL parity_bad: got %0d parity errs %0d strobes, required %0d and 0",
                     n_perr, obs_q.size(), exp_perr);
        end
        obs_q.delete();
        send_byte(8'h01, 1'b1, 1'b0);
        model_push(8'h01);
        repeat (4) @(posedge clk);
        n_cmp++;
        if (obs_q.size() !== 1 || obs_q[0] !== exp_q[0] || n_perr !== exp_perr) begin
            n_mis++;
            $display("FAIL parity_good: got %0d strobes %0d parity errs, required 1 strobe %h",
                     obs_q.size(), n_perr, exp_q[0]);
        end
        exp_q.delete(); obs_q.delete();
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back();
        test_framing();
        test_glitch();
        test_clear_and_reset();
        test_random();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
